dmem_responder: RTL and testbench

- Memory-side responder for the pipeline's MEM-stage data port.
- Accepts the core's MemRead/MemWrite request and holds the core with Stall for a fixed number of wait cycles.
- Then completes the access with a one-cycle Ack, carrying aligned and extended load data.
- Replaces the combinational data memory, so the pipeline can be exercised against realistic multi-cycle memory latency.

---
 rtl/dmem_responder_pkg.sv | 32 +++
 rtl/mem_lane_align.sv | 64 ++++++
 rtl/dmem_responder.sv | 179 +++++++++++++++++
 tb/tb_dmem_responder.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_responder_pkg.sv
// -----------------------------------------------------------------------------
// dmem_responder_pkg
//   Shared definitions for the multi-cycle data-memory responder:
//   access-size encodings, FSM state encoding and the access-legality check.
//   No ports (package).
// -----------------------------------------------------------------------------
package dmem_responder_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // 1 when the access is misaligned for its size or uses the reserved size.
    function automatic logic access_err(input logic [1:0] size,
                                        input logic [1:0] offset);
        logic bad;
        case (size)
            SIZE_BYTE: bad = 1'b0;
            SIZE_HALF: bad = offset[0];
            SIZE_WORD: bad = (offset != 2'b00);
            default:   bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// -----------------------------------------------------------------------------
// mem_lane_align
//   Purely combinational byte-lane steering for the data memory.
//   Store side: merges right-justified store data into the old word.
//   Load side : extracts the addressed lane and sign/zero-extends it.
//
//   store_old     in  32  current contents of the addressed word
//   store_data    in  32  store data, right-justified for byte/half
//   store_size    in   2  access size
//   store_offset  in   2  byte offset within the word
//   store_word    out 32  word to write back
//   load_word     in  32  word read from memory
//   load_size     in   2  access size
//   load_offset   in   2  byte offset within the word
//   load_unsigned in   1  1 = zero-extend, 0 = sign-extend
//   load_data     out 32  aligned, extended load result
// -----------------------------------------------------------------------------
module mem_lane_align
    import dmem_responder_pkg::*;
(
    input  logic [31:0] store_old,
    input  logic [31:0] store_data,
    input  logic [1:0]  store_size,
    input  logic [1:0]  store_offset,
    output logic [31:0] store_word,
    input  logic [31:0] load_word,
    input  logic [1:0]  load_size,
    input  logic [1:0]  load_offset,
    input  logic        load_unsigned,
    output logic [31:0] load_data
);

    logic [7:0]  load_byte;
    logic [15:0] load_half;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // so no path through the case statement can leave it unassigned and
        // infer a latch.
        store_word = store_old;
        case (store_size)
            SIZE_BYTE: store_word[{store_offset, 3'b000} +: 8] = store_data[7:0];
            SIZE_HALF: begin
                if (store_offset[1]) store_word[31:16] = store_data[15:0];
                else                 store_word[15:0]  = store_data[15:0];
            end
            SIZE_WORD: store_word = store_data;
            default:   store_word = store_old;
        endcase
    end

    always_comb begin
        load_byte = load_word[{load_offset, 3'b000} +: 8];
        load_half = load_offset[1] ? load_word[31:16] : load_word[15:0];
        load_data = '0;
        case (load_size)
            SIZE_BYTE: load_data = {{24{~load_unsigned & load_byte[7]}}, load_byte};
            SIZE_HALF: load_data = {{16{~load_unsigned & load_half[15]}}, load_half};
            SIZE_WORD: load_data = load_word;
            default:   load_data = '0;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//   Memory-side responder for the MEM-stage data port. A request is accepted
//   in IDLE, the core is held with Stall for WAIT_CYCLES cycles, and the
//   access completes with a one-cycle Ack (plus Err for illegal accesses).
//
//   Clk       in   1  clock, rising edge
//   Reset     in   1  asynchronous, active-low reset
//   Address   in  32  byte address
//   WriteData in  32  store data, right-justified for sb/sh
//   MemRead   in   1  load request
//   MemWrite  in   1  store request
//   Size      in   2  00 byte, 01 half, 10 word, 11 reserved
//   Unsigned  in   1  1 zero-extends loads, 0 sign-extends
//   ReadData  out 32  load data, valid while Ack=1, otherwise 0
//   Stall     out  1  pipeline freeze
//   Ack       out  1  one-cycle completion pulse
//   Err       out  1  one-cycle error pulse, coincident with Ack
// -----------------------------------------------------------------------------
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [1:0]  Size,
    input  logic        Unsigned,
    output logic [31:0] ReadData,
    output logic        Stall,
    output logic        Ack,
    output logic        Err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_CYCLES - 1);

    state_t         state;
    logic [CW-1:0]  cnt;

    // Request captured at acceptance.
    logic [AW-1:0]  req_idx;
    logic [1:0]     req_off;
    logic [31:0]    req_wdata;
    logic [1:0]     req_size;
    logic           req_uns;
    logic           req_write;
    logic           req_both;

    logic [31:0]    mem [DEPTH];

    logic           req;
    logic           in_idle;
    logic           to_resp;
    logic [AW-1:0]  cur_idx;
    logic [1:0]     cur_off;
    logic [1:0]     cur_size;
    logic           cur_uns;
    logic           cur_write;
    logic           cur_both;
    logic           cur_bad;
    logic           resp_err;
    logic [31:0]    resp_data;
    logic [31:0]    store_word;
    logic [31:0]    load_data;
    logic           commit;

    // Address bits above the word index alias back into the array.
    logic           unused_addr_bits;
    assign unused_addr_bits = ^Address[31:AW+2];

    assign req     = MemRead | MemWrite;
    assign in_idle = (state == ST_IDLE);

    // Stall is held low while in reset so the core is released immediately,
    // even if it keeps its request asserted.
    assign Stall = Reset & ((in_idle & req) | (state == ST_WAIT));

    // The response is formed on the edge into RESP. With WAIT_CYCLES=1 that
    // edge is the acceptance edge itself, so the request is taken from the
    // live inputs while in IDLE and from the captured copy otherwise.
    assign to_resp = (in_idle & req & (WAIT_CYCLES == 1)) |
                     ((state == ST_WAIT) & (cnt == CNT_LAST));

    assign cur_idx   = in_idle ? Address[AW+1:2]      : req_idx;
    assign cur_off   = in_idle ? Address[1:0]         : req_off;
    assign cur_size  = in_idle ? Size                 : req_size;
    assign cur_uns   = in_idle ? Unsigned             : req_uns;
    assign cur_write = in_idle ? MemWrite             : req_write;
    assign cur_both  = in_idle ? (MemRead & MemWrite) : req_both;

    assign cur_bad   = access_err(cur_size, cur_off);
    // A simultaneous read+write is flagged but still executes as a store.
    assign resp_err  = cur_bad | cur_both;
    assign resp_data = (!cur_write && !cur_bad) ? load_data : '0;

    // Stores commit on the RESP->IDLE edge; a reset before then drops them.
    assign commit = (state == ST_RESP) & req_write & ~access_err(req_size, req_off);

    mem_lane_align u_align (
        .store_old     (mem[req_idx]),
        .store_data    (req_wdata),
        .store_size    (req_size),
        .store_offset  (req_off),
        .store_word    (store_word),
        .load_word     (mem[cur_idx]),
        .load_size     (cur_size),
        .load_offset   (cur_off),
        .load_unsigned (cur_uns),
        .load_data     (load_data)
    );

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            req_idx   <= '0;
            req_off   <= '0;
            req_wdata <= '0;
            req_size  <= '0;
            req_uns   <= 1'b0;
            req_write <= 1'b0;
            req_both  <= 1'b0;
            Ack       <= 1'b0;
            Err       <= 1'b0;
            ReadData  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            Ack      <= to_resp;
            Err      <= to_resp & resp_err;
            ReadData <= to_resp ? resp_data : '0;

            case (state)
                ST_IDLE: begin
                    if (req) begin
                        req_idx   <= Address[AW+1:2];
                        req_off   <= Address[1:0];
                        req_wdata <= WriteData;
                        req_size  <= Size;
                        req_uns   <= Unsigned;
                        req_write <= MemWrite;
                        req_both  <= MemRead & MemWrite;
                        if (WAIT_CYCLES == 1) begin
                            state <= ST_RESP;
                        end else begin
                            state <= ST_WAIT;
                            cnt   <= CNT_ONE;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt == CNT_LAST) begin
                        state <= ST_RESP;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // NOTE: the memory array is deliberately not reset; contents survive a
    // reset, and leaving it out keeps the array mappable onto RAM.
    always_ff @(posedge Clk) begin
        if (commit) mem[req_idx] <= store_word;
    end

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
//   Self-checking bench for dmem_responder. u_dut uses WAIT_CYCLES=2 for the
//   directed load/store/error/reset sequence; u_dut1 uses WAIT_CYCLES=1 for
//   back-to-back timing. Expected responses are queued when a request is
//   driven and compared when Ack appears.
// -----------------------------------------------------------------------------
module tb_dmem_responder;
    import dmem_responder_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    always #5 clk = ~clk;

    // WAIT_CYCLES=2 instance
    logic [31:0] address, write_data, read_data;
    logic        mem_read, mem_write, uns, stall, ack, err;
    logic [1:0]  size;

    // WAIT_CYCLES=1 instance
    logic [31:0] b_address, b_write_data, b_read_data;
    logic        b_mem_read, b_mem_write, b_uns, b_stall, b_ack, b_err;
    logic [1:0]  b_size;

    dmem_responder #(.DEPTH(1024), .WAIT_CYCLES(2)) u_dut (
        .Clk(clk), .Reset(rst_n), .Address(address), .WriteData(write_data),
        .MemRead(mem_read), .MemWrite(mem_write), .Size(size), .Unsigned(uns),
        .ReadData(read_data), .Stall(stall), .Ack(ack), .Err(err)
    );

    dmem_responder #(.DEPTH(1024), .WAIT_CYCLES(1)) u_dut1 (
        .Clk(clk), .Reset(rst_n), .Address(b_address), .WriteData(b_write_data),
        .MemRead(b_mem_read), .MemWrite(b_mem_write), .Size(b_size), .Unsigned(b_uns),
        .ReadData(b_read_data), .Stall(b_stall), .Ack(b_ack), .Err(b_err)
    );

    typedef struct {
        string       tag;
        logic [31:0] data;
        logic        err;
        logic        is_load;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One complete access on u_dut (WAIT_CYCLES=2): request at cycle 0,
    // stall through cycle 1, Ack at cycle 2, ReadData cleared at cycle 3.
    task automatic access(input string tag, input logic wr, input logic rd,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [1:0] sz, input logic un,
                          input logic [31:0] exp_data, input logic exp_err);
        exp_t e;
        int   n;
        @(negedge clk);
        address = addr; write_data = wdata; mem_read = rd; mem_write = wr;
        size = sz; uns = un;
        sb.push_back('{tag, exp_data, exp_err, rd && !wr});
        #1 chk({tag, "/stall_c0"}, stall, 1);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
            if (!ack) chk({tag, "/stall_wait"}, stall, 1);
        end while (!ack && n < 10);
        mem_read = 1'b0; mem_write = 1'b0;
        chk({tag, "/ack_latency"}, n, 2);
        e = sb.pop_front();
        if (ack) begin
            chk({e.tag, "/err"}, err, e.err);
            if (e.is_load) chk({e.tag, "/rdata"}, read_data, e.data);
            chk({e.tag, "/stall_resp"}, stall, 0);
        end
        @(posedge clk); #1;
        chk({tag, "/rdata_clear"}, read_data, 0);
        chk({tag, "/ack_clear"}, ack, 0);
    endtask

    task automatic drive_b(input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] exp_data);
        b_address = addr; b_write_data = wdata; b_mem_write = wr; b_mem_read = !wr;
        b_size = SIZE_WORD; b_uns = 1'b0;
        sb.push_back('{wr ? "b2b_sw" : "b2b_lw", exp_data, 1'b0, !wr});
    endtask

    task automatic drive_b_step(input int k);
        case (k)
            0:       drive_b(1'b1, 32'h0000_0008, 32'h55AA_33CC, 32'h0);
            1:       drive_b(1'b0, 32'h0000_0008, 32'h0,         32'h55AA_33CC);
            2:       drive_b(1'b1, 32'h0000_1008, 32'h0000_0001, 32'h0);
            default: drive_b(1'b0, 32'h0000_0008, 32'h0,         32'h0000_0001);
        endcase
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   acks;
        int   next;

        rst_n = 1'b0;
        address = '0; write_data = '0; mem_read = 1'b0; mem_write = 1'b0; size = '0; uns = 1'b0;
        b_address = '0; b_write_data = '0; b_mem_read = 1'b0; b_mem_write = 1'b0; b_size = '0; b_uns = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset/stall", stall, 0);
        chk("reset/ack", ack, 0);
        chk("reset/err", err, 0);
        chk("reset/rdata", read_data, 0);
        rst_n = 1'b1;

        // Word store / load
        access("sw_10", 1, 0, 32'h10, 32'hDEAD_BEEF, SIZE_WORD, 0, 32'h0, 0);
        access("lw_10", 0, 1, 32'h10, 32'h0, SIZE_WORD, 0, 32'hDEAD_BEEF, 0);

        // Byte store, signed/unsigned byte loads
        access("sw0_10", 1, 0, 32'h10, 32'h0, SIZE_WORD, 0, 32'h0, 0);
        access("sb_13", 1, 0, 32'h13, 32'h80, SIZE_BYTE, 0, 32'h0, 0);
        access("lb_13", 0, 1, 32'h13, 32'h0, SIZE_BYTE, 0, 32'hFFFF_FF80, 0);
        access("lbu_13", 0, 1, 32'h13, 32'h0, SIZE_BYTE, 1, 32'h0000_0080, 0);
        access("lw_10b", 0, 1, 32'h10, 32'h0, SIZE_WORD, 0, 32'h8000_0000, 0);

        // Half store / load
        access("sw0_14", 1, 0, 32'h14, 32'h0, SIZE_WORD, 0, 32'h0, 0);
        access("sh_16", 1, 0, 32'h16, 32'h1234, SIZE_HALF, 0, 32'h0, 0);
        access("lh_16", 0, 1, 32'h16, 32'h0, SIZE_HALF, 0, 32'h0000_1234, 0);
        access("lw_14", 0, 1, 32'h14, 32'h0, SIZE_WORD, 0, 32'h1234_0000, 0);

        // Sign/zero extension of negative halves and a positive byte lane
        access("sw_18", 1, 0, 32'h18, 32'h8001_7F00, SIZE_WORD, 0, 32'h0, 0);
        access("lh_1a", 0, 1, 32'h1A, 32'h0, SIZE_HALF, 0, 32'hFFFF_8001, 0);
        access("lhu_1a", 0, 1, 32'h1A, 32'h0, SIZE_HALF, 1, 32'h0000_8001, 0);
        access("lb_19", 0, 1, 32'h19, 32'h0, SIZE_BYTE, 0, 32'h0000_007F, 0);

        // Misaligned / reserved accesses
        access("lw_11", 0, 1, 32'h11, 32'h0, SIZE_WORD, 0, 32'h0, 1);
        access("sw_20", 1, 0, 32'h20, 32'hCAFE_F00D, SIZE_WORD, 0, 32'h0, 0);
        access("sh_21", 1, 0, 32'h21, 32'hBEEF, SIZE_HALF, 0, 32'h0, 1);
        access("lw_20", 0, 1, 32'h20, 32'h0, SIZE_WORD, 0, 32'hCAFE_F00D, 0);
        access("rsv_20", 0, 1, 32'h20, 32'h0, 2'b11, 0, 32'h0, 1);

        // Read+write together: flagged, still stored when aligned
        access("rw_30", 1, 1, 32'h30, 32'h1234_5678, SIZE_WORD, 0, 32'h0, 1);
        access("lw_30", 0, 1, 32'h30, 32'h0, SIZE_WORD, 0, 32'h1234_5678, 0);

        // Address wrap: 0x1000 aliases 0x0
        access("sw_1000", 1, 0, 32'h1000, 32'h0BAD_CAFE, SIZE_WORD, 0, 32'h0, 0);
        access("lw_0", 0, 1, 32'h0, 32'h0, SIZE_WORD, 0, 32'h0BAD_CAFE, 0);

        // Reset during the wait cycle drops the pending store
        access("sw_40", 1, 0, 32'h40, 32'h1111_2222, SIZE_WORD, 0, 32'h0, 0);
        @(negedge clk);
        address = 32'h40; write_data = 32'hAAAA_5555; mem_write = 1'b1; size = SIZE_WORD;
        #1 chk("abort/stall_c0", stall, 1);
        @(posedge clk); #2;
        chk("abort/stall_c1", stall, 1);
        rst_n = 1'b0;
        #1;
        chk("abort/stall_drop", stall, 0);
        chk("abort/ack_drop", ack, 0);
        mem_write = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("abort/no_ack", ack, 0);
        end
        access("lw_40", 0, 1, 32'h40, 32'h0, SIZE_WORD, 0, 32'h1111_2222, 0);

        // Back-to-back on WAIT_CYCLES=1: Ack every second cycle
        acks = 0;
        @(negedge clk);
        drive_b_step(0);
        next = 1;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            if (b_ack) begin
                acks++;
                chk("b2b/ack_cycle", c, 2 * acks - 1);
                if (sb.size() == 0) begin
                    chk("b2b/spurious_ack", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk({e.tag, "/err"}, b_err, e.err);
                    if (e.is_load) chk({e.tag, "/rdata"}, b_read_data, e.data);
                end
                chk("b2b/stall_resp", b_stall, 0);
                if (next < 4) begin
                    drive_b_step(next);
                    next++;
                end else begin
                    b_mem_read = 1'b0; b_mem_write = 1'b0;
                end
            end else begin
                chk("b2b/stall", b_stall, (acks < 4) ? 1 : 0);
            end
        end
        chk("b2b/ack_count", acks, 4);
        chk("b2b/sb_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
